// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and constants for the ADC emulator
package adc_pkg;

  typedef enum logic [1:0] {
    PAT_INPUT = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CONST = 2'd2
  } pattern_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } conv_state_e;

  localparam int AVG_LOG2_MAX = 4;

  function automatic logic [2:0] clamp_avg_log2(input logic [2:0] v);
    return (v > 3'(AVG_LOG2_MAX)) ? 3'(AVG_LOG2_MAX) : v;
  endfunction

endpackage

// File: rtl/adc_emulator_spi_tx.sv
// rtl/adc_emulator_spi_tx.sv - SPI mode-0 transmit path: edge detect, shift register, sdo
module adc_emulator_spi_tx #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  cs_n,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  output logic                  o_cs_fall,
  output logic                  sdo
);

  logic                  r_sck_prev;
  logic                  r_cs_prev;
  logic                  r_sdo;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  w_sck_fall;
  logic                  w_cs_fall;

  assign w_sck_fall = r_sck_prev & ~sck;
  assign w_cs_fall  = r_cs_prev & ~cs_n;

  // Zeros fill from the right, so clocking past the last bit naturally drives 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sck_prev <= 1'b0;
      r_cs_prev  <= 1'b1;
      r_shift    <= '0;
      r_sdo      <= 1'b0;
    end else begin
      r_sck_prev <= sck;
      r_cs_prev  <= cs_n;
      if (w_cs_fall) begin
        r_shift <= i_load_data;
        r_sdo   <= i_load_data[DATA_WIDTH-1];
      end else if (cs_n) begin
        r_sdo <= 1'b0;
      end else if (w_sck_fall) begin
        r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
        r_sdo   <= r_shift[DATA_WIDTH-2];
      end
    end
  end

  assign o_cs_fall = w_cs_fall;
  assign sdo       = r_sdo;

endmodule

// File: rtl/adc_emulator.sv
// rtl/adc_emulator.sv - ADC emulator top: conversion FSM, averaging, error flags
module adc_emulator
  import adc_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 24,
  parameter int                    CNV_CYCLES    = 15,
  parameter logic [DATA_WIDTH-1:0] CONST_PATTERN = DATA_WIDTH'(24'hA5A5A5)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cnv,
  output logic                  busy,
  input  logic                  sck,
  input  logic                  cs_n,
  output logic                  sdo,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            pattern_sel,
  input  logic [2:0]            avg_log2,
  input  logic                  err_clear,
  output logic                  err_cnv_busy,
  output logic                  err_read_busy,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int ACC_W = DATA_WIDTH + 4;
  localparam int CNT_W = $clog2(CNV_CYCLES + 1);

  conv_state_e           r_state;
  logic                  r_busy;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_sample;
  logic [DATA_WIDTH-1:0] r_ramp;
  logic [ACC_W-1:0]      r_acc;
  logic [4:0]            r_avg_cnt;
  logic [2:0]            r_avg_prev;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_cnv_prev;
  logic                  r_err_cnv;
  logic                  r_err_read;

  logic                  w_cnv_rise;
  logic                  w_cs_fall;
  logic [2:0]            w_avg_eff;
  logic                  w_avg_chg;
  logic [ACC_W-1:0]      w_acc_base;
  logic [4:0]            w_cnt_base;
  logic [ACC_W-1:0]      w_acc_sum;
  logic [4:0]            w_cnt_inc;
  logic                  w_done;
  logic                  w_avg_full;
  logic [DATA_WIDTH-1:0] w_result_next;
  logic [DATA_WIDTH-1:0] w_src;

  assign w_cnv_rise = cnv & ~r_cnv_prev;
  assign w_avg_eff  = clamp_avg_log2(avg_log2);

  // A new averaging exponent invalidates any partial sum gathered under the old one.
  assign w_avg_chg  = (w_avg_eff != r_avg_prev) && (r_avg_cnt != '0);
  assign w_acc_base = w_avg_chg ? '0 : r_acc;
  assign w_cnt_base = w_avg_chg ? '0 : r_avg_cnt;
  assign w_acc_sum  = w_acc_base + ACC_W'(r_sample);
  assign w_cnt_inc  = w_cnt_base + 5'd1;
  assign w_done     = (r_state == ST_CONV) && (r_cnt == '0);
  assign w_avg_full = (w_cnt_inc == (5'd1 << w_avg_eff));

  assign w_result_next = (w_done && w_avg_full) ?
                         DATA_WIDTH'(w_acc_sum >> w_avg_eff) : r_result;

  always_comb begin
    w_src = data_in;
    case (pattern_sel_e'(pattern_sel))
      PAT_RAMP:  w_src = r_ramp;
      PAT_CONST: w_src = CONST_PATTERN;
      default:   w_src = data_in;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_cnt      <= '0;
      r_sample   <= '0;
      r_ramp     <= '0;
      r_acc      <= '0;
      r_avg_cnt  <= '0;
      r_avg_prev <= '0;
      r_result   <= '0;
      r_cnv_prev <= 1'b0;
    end else begin
      r_cnv_prev <= cnv;
      r_avg_prev <= w_avg_eff;
      r_result   <= w_result_next;
      if (!w_done && w_avg_chg) begin
        r_acc     <= '0;
        r_avg_cnt <= '0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_cnv_rise) begin
            r_busy   <= 1'b1;
            r_cnt    <= CNT_W'(CNV_CYCLES - 1);
            r_sample <= w_src;
            r_state  <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (r_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
            r_ramp  <= r_ramp + 1'b1;
            if (w_avg_full) begin
              r_acc     <= '0;
              r_avg_cnt <= '0;
            end else begin
              r_acc     <= w_acc_sum;
              r_avg_cnt <= w_cnt_inc;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Setting wins over a simultaneous clear so no protocol violation is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnv  <= 1'b0;
      r_err_read <= 1'b0;
    end else begin
      if (w_cnv_rise && r_busy) r_err_cnv <= 1'b1;
      else if (err_clear)       r_err_cnv <= 1'b0;
      if (w_cs_fall && r_busy)  r_err_read <= 1'b1;
      else if (err_clear)       r_err_read <= 1'b0;
    end
  end

  adc_emulator_spi_tx #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_spi_tx (
    .clk        (clk),
    .reset      (reset),
    .sck        (sck),
    .cs_n       (cs_n),
    .i_load_data(w_result_next),
    .o_cs_fall  (w_cs_fall),
    .sdo        (sdo)
  );

  assign busy          = r_busy;
  assign result        = r_result;
  assign err_cnv_busy  = r_err_cnv;
  assign err_read_busy = r_err_read;

endmodule

// File: tb/tb_adc_emulator.sv
// tb/tb_adc_emulator.sv - scoreboard bench for adc_emulator
module tb_adc_emulator;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          cnv;
  logic          busy;
  logic          sck;
  logic          cs_n;
  logic          sdo;
  logic [DW-1:0] data_in;
  logic [1:0]    pattern_sel;
  logic [2:0]    avg_log2;
  logic          err_clear;
  logic          err_cnv_busy;
  logic          err_read_busy;
  logic [DW-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0]   exp_q[$];
  logic [DW-1:0]   m_ramp;
  logic [DW-1:0]   m_result;
  logic [DW+3:0]   m_acc;
  int              m_cnt;
  int              m_avg_prev;

  adc_emulator #(
    .DATA_WIDTH   (DW),
    .CNV_CYCLES   (15),
    .CONST_PATTERN(24'hA5A5A5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cnv          (cnv),
    .busy         (busy),
    .sck          (sck),
    .cs_n         (cs_n),
    .sdo          (sdo),
    .data_in      (data_in),
    .pattern_sel  (pattern_sel),
    .avg_log2     (avg_log2),
    .err_clear    (err_clear),
    .err_cnv_busy (err_cnv_busy),
    .err_read_busy(err_read_busy),
    .result       (result)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_ramp     = '0;
    m_result   = '0;
    m_acc      = '0;
    m_cnt      = 0;
    m_avg_prev = 0;
    exp_q.delete();
  endtask

  task automatic model_conv;
    logic [DW-1:0] s;
    int a;
    a = (avg_log2 > 3'd4) ? 4 : int'(avg_log2);
    case (pattern_sel)
      2'd1:    s = m_ramp;
      2'd2:    s = 24'hA5A5A5;
      default: s = data_in;
    endcase
    if (a != m_avg_prev && m_cnt != 0) begin
      m_acc = '0;
      m_cnt = 0;
    end
    m_avg_prev = a;
    m_acc = m_acc + (DW+4)'(s);
    m_cnt++;
    if (m_cnt == (1 << a)) begin
      m_result = DW'(m_acc >> a);
      exp_q.push_back(m_result);
      m_acc = '0;
      m_cnt = 0;
    end
    m_ramp = m_ramp + 1'b1;
  endtask

  task automatic do_cnv(output int nbusy, input int err_at, input bit clr_with);
    cnv = 1'b1;
    model_conv();
    tick();
    cnv = 1'b0;
    nbusy = 0;
    while (busy && nbusy < 100) begin
      nbusy++;
      cnv       = (nbusy == err_at);
      err_clear = (nbusy == err_at) && clr_with;
      tick();
    end
    cnv       = 1'b0;
    err_clear = 1'b0;
    repeat (4) tick();
  endtask

  task automatic spi_clock_bits(input int nbits, output logic [DW:0] w);
    w = '0;
    for (int i = 0; i < nbits; i++) begin
      w = {w[DW-1:0], sdo};
      sck = 1'b1;
      repeat (4) tick();
      sck = 1'b0;
      repeat (4) tick();
    end
  endtask

  task automatic spi_read(input int nbits, output logic [DW:0] w);
    cs_n = 1'b0;
    repeat (4) tick();
    spi_clock_bits(nbits, w);
    cs_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset;
    reset = 1'b1; cnv = 1'b0; sck = 1'b0; cs_n = 1'b1; data_in = '0;
    pattern_sel = 2'd0; avg_log2 = 3'd0; err_clear = 1'b0;
    model_reset();
    repeat (3) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (sdo !== 1'b0) begin n_fail++; $display("FAIL reset_sdo: got %0b want 0", sdo); end
    n_checks++; if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_checks++; if (err_cnv_busy !== 1'b0 || err_read_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_errs: got %b%b want 00", err_cnv_busy, err_read_busy);
    end
    reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_ramp_avg;
    int n;
    logic [DW:0] w;
    logic [DW-1:0] e;
    pattern_sel = 2'd1;
    avg_log2    = 3'd2;
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 4; i++) begin
        do_cnv(n, 0, 1'b0);
        n_checks++; if (n !== 15) begin n_fail++; $display("FAIL ramp_busy_len: got %0d want 15", n); end
        if (i < 3) begin
          n_checks++;
          if (result !== ((g == 0) ? 24'd0 : 24'd1)) begin
            n_fail++; $display("FAIL ramp_partial g%0d i%0d: got %h want %h", g, i, result, (g == 0) ? 24'd0 : 24'd1);
          end
        end
      end
      n_checks++;
      if (result !== ((g == 0) ? 24'd1 : 24'd5)) begin
        n_fail++; $display("FAIL ramp_avg_result g%0d: got %h want %h", g, result, (g == 0) ? 24'd1 : 24'd5);
      end
      spi_read(DW, w);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL ramp_read: got %h want <scoreboard entry>", w[DW-1:0]);
      end else begin
        e = exp_q.pop_front();
        if (w[DW-1:0] !== e) begin n_fail++; $display("FAIL ramp_read: got %h want %h", w[DW-1:0], e); end
      end
    end
  endtask

  task automatic test_single;
    int n;
    logic [DW:0] w;
    logic [DW-1:0] e;
    pattern_sel = 2'd2;
    avg_log2    = 3'd0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %0b want 0", busy); end
    do_cnv(n, 0, 1'b0);
    n_checks++; if (n !== 15) begin n_fail++; $display("FAIL single_busy_len: got %0d want 15", n); end
    n_checks++; if (result !== 24'hA5A5A5) begin n_fail++; $display("FAIL single_result: got %h want a5a5a5", result); end
    spi_read(DW, w);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL single_read: got %h want <scoreboard entry>", w[DW-1:0]);
    end else begin
      e = exp_q.pop_front();
      if (w[DW-1:0] !== e) begin n_fail++; $display("FAIL single_read: got %h want %h", w[DW-1:0], e); end
    end
    n_checks++; if (sdo !== 1'b0) begin n_fail++; $display("FAIL single_sdo_idle: got %0b want 0", sdo); end
  endtask

  task automatic test_external;
    int n;
    logic [DW:0] w;
    logic [DW-1:0] e;
    pattern_sel = 2'd0;
    avg_log2    = 3'd0;
    data_in     = 24'h800001;
    do_cnv(n, 0, 1'b0);
    spi_read(DW + 1, w);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL ext_read: got %h want <scoreboard entry>", w[DW:1]);
    end else begin
      e = exp_q.pop_front();
      if (w[DW:1] !== e) begin n_fail++; $display("FAIL ext_read: got %h want %h", w[DW:1], e); end
    end
    n_checks++; if (w[0] !== 1'b0) begin n_fail++; $display("FAIL ext_bit25: got %0b want 0", w[0]); end
  endtask

  task automatic test_avg_change_clamp;
    int n;
    logic [DW:0] w;
    logic [DW-1:0] e;
    pattern_sel = 2'd0;
    avg_log2    = 3'd1;
    data_in     = 24'h000100;
    do_cnv(n, 0, 1'b0);
    avg_log2 = 3'd0;
    data_in  = 24'h000007;
    repeat (2) tick();
    do_cnv(n, 0, 1'b0);
    n_checks++; if (result !== 24'h000007) begin n_fail++; $display("FAIL avg_discard: got %h want 000007", result); end
    spi_read(DW, w);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL avg_discard_read: got %h want <scoreboard entry>", w[DW-1:0]);
    end else begin
      e = exp_q.pop_front();
      if (w[DW-1:0] !== e) begin n_fail++; $display("FAIL avg_discard_read: got %h want %h", w[DW-1:0], e); end
    end
    pattern_sel = 2'd1;
    avg_log2    = 3'd7;
    for (int i = 0; i < 16; i++) do_cnv(n, 0, 1'b0);
    spi_read(DW, w);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL avg_clamp_read: got %h want <scoreboard entry>", w[DW-1:0]);
    end else begin
      e = exp_q.pop_front();
      if (w[DW-1:0] !== e) begin n_fail++; $display("FAIL avg_clamp_read: got %h want %h", w[DW-1:0], e); end
    end
    avg_log2 = 3'd0;
    repeat (2) tick();
  endtask

  task automatic test_errors;
    int n;
    logic [DW:0] w;
    logic [DW-1:0] e;
    logic [DW-1:0] prev;
    pattern_sel = 2'd2;
    avg_log2    = 3'd0;
    do_cnv(n, 5, 1'b0);
    n_checks++; if (n !== 15) begin n_fail++; $display("FAIL err_cnv_len: got %0d want 15", n); end
    n_checks++; if (err_cnv_busy !== 1'b1) begin n_fail++; $display("FAIL err_cnv_set: got %0b want 1", err_cnv_busy); end
    n_checks++; if (busy !== 1'b0 || err_read_busy !== 1'b0) begin
      n_fail++; $display("FAIL err_cnv_side: got busy=%0b rd=%0b want 0 0", busy, err_read_busy);
    end
    spi_read(DW, w);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL err_cnv_read: got %h want <scoreboard entry>", w[DW-1:0]);
    end else begin
      e = exp_q.pop_front();
      if (w[DW-1:0] !== e) begin n_fail++; $display("FAIL err_cnv_read: got %h want %h", w[DW-1:0], e); end
    end

    prev        = m_result;
    pattern_sel = 2'd0;
    data_in     = 24'h123456;
    cnv = 1'b1;
    model_conv();
    tick();
    cnv = 1'b0;
    repeat (3) tick();
    cs_n = 1'b0;
    n = 0;
    while (busy && n < 100) begin n++; tick(); end
    n_checks++; if (n >= 100) begin n_fail++; $display("FAIL err_read_wait: got timeout want busy low"); end
    repeat (4) tick();
    spi_clock_bits(DW, w);
    cs_n = 1'b1;
    repeat (4) tick();
    n_checks++; if (w[DW-1:0] !== prev) begin n_fail++; $display("FAIL err_read_prev: got %h want %h", w[DW-1:0], prev); end
    n_checks++; if (err_read_busy !== 1'b1) begin n_fail++; $display("FAIL err_read_set: got %0b want 1", err_read_busy); end
    spi_read(DW, w);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL err_read_new: got %h want <scoreboard entry>", w[DW-1:0]);
    end else begin
      e = exp_q.pop_front();
      if (w[DW-1:0] !== e) begin n_fail++; $display("FAIL err_read_new: got %h want %h", w[DW-1:0], e); end
    end

    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    tick();
    n_checks++; if (err_cnv_busy !== 1'b0 || err_read_busy !== 1'b0) begin
      n_fail++; $display("FAIL err_clear: got %b%b want 00", err_cnv_busy, err_read_busy);
    end

    do_cnv(n, 5, 1'b1);
    n_checks++; if (err_cnv_busy !== 1'b1) begin n_fail++; $display("FAIL err_set_wins: got %0b want 1", err_cnv_busy); end
    spi_read(DW, w);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL err_setclr_read: got %h want <scoreboard entry>", w[DW-1:0]);
    end else begin
      e = exp_q.pop_front();
      if (w[DW-1:0] !== e) begin n_fail++; $display("FAIL err_setclr_read: got %h want %h", w[DW-1:0], e); end
    end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    int n;
    logic [DW:0] w;
    logic [DW-1:0] e;
    pattern_sel = 2'd2;
    avg_log2    = 3'd0;
    do_cnv(n, 0, 1'b0);
    exp_q.delete();
    cs_n = 1'b0;
    repeat (4) tick();
    spi_clock_bits(10, w);
    n_checks++; if (sdo !== 1'b1) begin n_fail++; $display("FAIL rst_read_bit10: got %0b want 1", sdo); end
    reset = 1'b1;
    #1;
    n_checks++; if (sdo !== 1'b0) begin n_fail++; $display("FAIL rst_read_sdo: got %0b want 0", sdo); end
    n_checks++; if (result !== '0) begin n_fail++; $display("FAIL rst_read_result: got %h want 0", result); end
    cs_n = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    repeat (2) tick();

    pattern_sel = 2'd1;
    cnv = 1'b1;
    tick();
    cnv = 1'b0;
    repeat (6) tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_conv_pre: got %0b want 1", busy); end
    reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_conv_busy: got %0b want 0", busy); end
    tick();
    reset = 1'b0;
    model_reset();
    repeat (2) tick();

    for (int i = 0; i < 2; i++) begin
      do_cnv(n, 0, 1'b0);
      n_checks++; if (n !== 15) begin n_fail++; $display("FAIL rst_after_len %0d: got %0d want 15", i, n); end
      n_checks++;
      if (result !== DW'(i)) begin n_fail++; $display("FAIL rst_ramp_restart %0d: got %h want %h", i, result, DW'(i)); end
      spi_read(DW, w);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL rst_after_read %0d: got %h want <scoreboard entry>", i, w[DW-1:0]);
      end else begin
        e = exp_q.pop_front();
        if (w[DW-1:0] !== e) begin n_fail++; $display("FAIL rst_after_read %0d: got %h want %h", i, w[DW-1:0], e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_avg();
    test_single();
    test_external();
    test_avg_change_clamp();
    test_errors();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_emulator.md
Name: adc_emulator

Overview:
- Synthesizable, cycle-based responder for the ADC conversion/readout protocol. It answers the `cnv` and `busy` interface driven by the conversion-trigger block, and also the serial readout driven by the acquisition master.
- Used in hardware-in-the-loop builds and in benches in place of the physical converter.
- Models conversion time, optional sample averaging, a selectable data source, SPI mode-0 readout and sticky protocol-error flags.

Parameters:
- DATA_WIDTH, 24, sample width in bits (range 8..32).
- CNV_CYCLES, 15, number of clk cycles `busy` stays high per conversion (≥ 2).
- CONST_PATTERN, 24'hA5A5A5, value returned when pattern_sel = 2.

Ports:
- clk  in  1  system clock; all inputs are synchronous to it.
- reset  in  1  asynchronous, active-high reset.
- cnv  in  1  conversion start; acts on rising edge.
- busy  out  1  high while a conversion is in progress.
- sck  in  1  serial clock from the readout master; at least 4 clk cycles per half-period.
- cs_n  in  1  active-low chip select.
- sdo  out  1  serial data, MSB first.
- data_in  in  DATA_WIDTH  external sample value (pattern_sel = 0).
- pattern_sel  in  2  data source: 0 data_in, 1 ramp, 2 CONST_PATTERN, 3 reserved (behaves as 0).
- avg_log2  in  3  averaging exponent, 0..4; values above 4 are clamped to 4.
- err_clear  in  1  clears the sticky error flags.
- err_cnv_busy  out  1  sticky: `cnv` rose while `busy` was high.
- err_read_busy  out  1  sticky: `cs_n` fell while `busy` was high.
- result  out  DATA_WIDTH  last completed (averaged) result, for debug.

Behaviour:
Reset:
- Asserting `reset` immediately forces the following, mid-conversion and mid-read included: busy=0, sdo=0, result=0, both error flags 0, ramp=0, accumulator=0, average count=0, FSM=IDLE.

Edge detection:
- `cnv`, `sck` and `cs_n` are each registered once; edges are detected as current value vs previous value.
- The previous-value registers reset to cnv=0, sck=0, cs_n=1.

Conversion FSM (states IDLE, CONV):
- IDLE: when a rising `cnv` is detected in cycle k, busy=1 from cycle k+1. Load the cycle counter with CNV_CYCLES-1, capture the source sample (data_in, ramp, or CONST_PATTERN), then go to CONV.
- CONV: decrement the counter each cycle. When it reaches 0, busy=0 in the following cycle, giving exactly CNV_CYCLES high cycles. Add the sample to the accumulator and increment the average count, then go to IDLE.
- Rising `cnv` during CONV: ignored; set err_cnv_busy.
- Ramp: increments by 1 after each completed conversion and wraps at 2^DATA_WIDTH.

Averaging:
- Accumulator width is DATA_WIDTH+4.
- When the average count reaches 2^avg_log2: result = accumulator >> avg_log2 (truncating), then clear the accumulator and the count.
- avg_log2=0 updates result after every conversion.
- A change of avg_log2 while the count is non-zero discards the partial accumulation.

Readout (SPI mode 0):
- Falling `cs_n`: load the shift register from `result`; sdo = result MSB from the next cycle.
- Each falling `sck` edge with cs_n low: shift left; sdo = next bit; zeros are shifted in.
- Rising `sck` edges have no internal action; the master samples on them.
- cs_n high: sdo=0 and the shift register holds.
- More than DATA_WIDTH bits clocked: sdo=0.
- Falling `cs_n` while busy=1: set err_read_busy; the load still uses the previous result.
- Simultaneous result update and `cs_n` fall in the same cycle: the load uses the new result.

Error flags:
- Set has priority over err_clear in the same cycle.
- Flags are cleared only by err_clear or reset.

Decomposition:
- Package adc_pkg holds:
  - pattern_sel_e enum (PAT_INPUT, PAT_RAMP, PAT_CONST), localparam AVG_LOG2_MAX = 4;
  - conversion FSM state typedef, shared with the trigger block's bench.
- One sub-module, adc_emulator_spi_tx: edge detection, shift register and sdo. The top level keeps the FSM, averaging and error flags.

Test Plan:
- Single conversion: reset released, pattern_sel=2, single `cnv` pulse → busy high exactly 15 cycles starting 1 cycle after the detected edge; then read 24 bits → 24'hA5A5A5.
- Ramp with averaging: pattern_sel=1, avg_log2=2, four `cnv` pulses spaced 20 cycles → result updates only after the 4th, to (0+1+2+3)>>2 = 1; next four → 5.
- External data: pattern_sel=0, data_in=24'h800001, avg_log2=0 → serial read returns 1000_0000_0000_0000_0000_0001 MSB first; a 25th sck returns sdo=0.
- Error flags: `cnv` pulse on busy cycle 5 → err_cnv_busy=1, busy still ends at cycle 15. `cs_n` fall during busy → err_read_busy=1. err_clear pulse → both 0. Set and clear in the same cycle → flag stays 1.
- Reset mid-operation: reset asserted at busy cycle 7 and mid-readout at bit 10 → busy=0, sdo=0 and result=0 immediately. The next `cnv` after release gives a full 15-cycle busy, with ramp restarting at 0.
